// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: instruction fetch sequencer with a small prefetch queue.
// Owns the program counter, issues one word read per cycle while the queue
// has room, and hands instructions to decode over a valid/ready handshake.
// Branch redirects flush the queue and reload the PC. A halt request
// suppresses new issues while already queued entries keep draining.
// Optional build macro IFETCH_STALL_CNT_EN adds the stall_cnt output, which
// counts cycles lost to a full queue.
module instr_fetch_ctrl #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] mem_addr,
  output logic        mem_rd_en,
  input  logic [31:0] mem_instr,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  output logic        instr_vld,
  input  logic        instr_rdy
`ifdef IFETCH_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [31:0]        pc_q;
  logic [PTR_W-1:0]   head_q;
  logic [PTR_W-1:0]   tail_q;
  logic [CNT_W-1:0]   count_q;
  logic [31:0]        q_instr [DEPTH];
  logic [31:0]        q_pc    [DEPTH];

  logic               full;
  logic               pop;
  logic               issue;
  logic               push;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign instr_vld = (count_q != '0);
  assign pop       = instr_vld & instr_rdy;
  // A pop frees a slot on the same edge, so a full queue can still issue.
  assign issue     = (state_q == FETCH) & ~halt & (~full | pop);
  // A redirect discards whatever was issued in its cycle.
  assign push      = issue & ~redirect;

  // Head entry is driven from queue registers; invalid head reads as zero.
  assign instr_out = instr_vld ? q_instr[head_q] : '0;
  assign instr_pc  = instr_vld ? q_pc[head_q]    : '0;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; redirect never changes state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = halt ? HALT : FETCH;
      FETCH:   state_d = halt ? HALT : FETCH;
      HALT:    state_d = halt ? HALT : FETCH;
      default: state_d = IDLE;
    endcase
  end

  // Memory-side outputs: the address is always the PC register.
  always_comb begin
    mem_rd_en = issue;
    mem_addr  = pc_q;
  end

  // PC and queue bookkeeping; redirect flushes and reloads the PC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (redirect) begin
      pc_q    <= redirect_pc;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        pc_q   <= pc_q + 32'd1;
        tail_q <= tail_q + PTR_W'(1);
      end
      if (pop) begin
        head_q <= head_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Queue storage: data only, validity is carried by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[tail_q] <= mem_instr;
      q_pc[tail_q]    <= pc_q;
    end
  end

`ifdef IFETCH_STALL_CNT_EN
  logic stall;

  assign stall = (state_q == FETCH) & ~halt & full & ~pop;

  // Saturating count of cycles where fetch was blocked by a full queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Table-driven bench for instr_fetch_ctrl (DEPTH=2, RESET_PC=0).
module tb_instr_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] mem_addr;
  logic        mem_rd_en;
  logic [31:0] mem_instr;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        instr_vld;
  logic        instr_rdy;
`ifdef IFETCH_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int checks;
  int failures;

  instr_fetch_ctrl #(
    .DEPTH    (2),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_addr    (mem_addr),
    .mem_rd_en   (mem_rd_en),
    .mem_instr   (mem_instr),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .instr_out   (instr_out),
    .instr_pc    (instr_pc),
    .instr_vld   (instr_vld),
    .instr_rdy   (instr_rdy)
`ifdef IFETCH_STALL_CNT_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  // Memory contents: each word is its address scrambled by a constant.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  assign mem_instr = memf(mem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        redir;
    logic [31:0] rpc;
    logic        hlt;
    logic        rdy;
    logic        e_rd;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_pc;
    logic        chk_st;
    logic [31:0] e_st;
  } vec_t;

  vec_t tbl [40];

  function automatic vec_t mk(input logic redir, input logic [31:0] rpc,
                              input logic hlt, input logic rdy,
                              input logic e_rd, input logic [31:0] e_addr,
                              input logic e_vld, input logic [31:0] e_pc,
                              input logic chk_st, input logic [31:0] e_st);
    vec_t v;
    v.redir = redir; v.rpc = rpc; v.hlt = hlt; v.rdy = rdy;
    v.e_rd = e_rd; v.e_addr = e_addr; v.e_vld = e_vld; v.e_pc = e_pc;
    v.chk_st = chk_st; v.e_st = e_st;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one vector's inputs, let combinational outputs settle, compare.
  task automatic apply_vec(input int i);
    redirect    = tbl[i].redir;
    redirect_pc = tbl[i].rpc;
    halt        = tbl[i].hlt;
    instr_rdy   = tbl[i].rdy;
    #1;
    chk($sformatf("v%0d.mem_rd_en", i), {31'd0, mem_rd_en}, {31'd0, tbl[i].e_rd});
    chk($sformatf("v%0d.mem_addr", i), mem_addr, tbl[i].e_addr);
    chk($sformatf("v%0d.instr_vld", i), {31'd0, instr_vld}, {31'd0, tbl[i].e_vld});
    if (tbl[i].e_vld) begin
      chk($sformatf("v%0d.instr_pc", i), instr_pc, tbl[i].e_pc);
      chk($sformatf("v%0d.instr_out", i), instr_out, memf(tbl[i].e_pc));
    end
`ifdef IFETCH_STALL_CNT_EN
    if (tbl[i].chk_st) begin
      chk($sformatf("v%0d.stall_cnt", i), stall_cnt, tbl[i].e_st);
    end
`endif
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // Segment A: streaming, backpressure, redirects, wrap, halt.
    //               redir rpc            hlt   rdy   rd    addr           vld   pc
    tbl[0]  = mk(1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0);
    tbl[1]  = mk(1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0);
    tbl[2]  = mk(1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h1,        1'b1, 32'h0,        1'b0, 32'h0);
    tbl[3]  = mk(1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h2,        1'b1, 32'h1,        1'b0, 32'h0);
    tbl[4]  = mk(1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h3,        1'b1, 32'h2,        1'b0, 32'h0);
    tbl[5]  = mk(1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h4,        1'b1, 32'h3,        1'b0, 32'h0);
    tbl[6]  = mk(1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h5,        1'b1, 32'h3,        1'b0, 32'h0);
    tbl[7]  = mk(1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h5,        1'b1, 32'h3,        1'b0, 32'h0);
    tbl[8]  = mk(1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h5,        1'b1, 32'h3,        1'b0, 32'h0);
    tbl[9]  = mk(1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h6,        1'b1, 32'h4,        1'b0, 32'h0);
    tbl[10] = mk(1'b1, 32'h100,      1'b0, 1'b0, 1'b0, 32'h7,        1'b1, 32'h5,        1'b0, 32'h0);
    tbl[11] = mk(1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h100,      1'b0, 32'h0,        1'b0, 32'h0);
    tbl[12] = mk(1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h101,      1'b1, 32'h100,      1'b0, 32'h0);
    tbl[13] = mk(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, 32'h102,     1'b1, 32'h101,      1'b0, 32'h0);
    tbl[14] = mk(1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0,       1'b0, 32'h0);
    tbl[15] = mk(1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h0,        1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0);
    tbl[16] = mk(1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h1,        1'b1, 32'h0,        1'b0, 32'h0);
    tbl[17] = mk(1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h2,        1'b1, 32'h1,        1'b0, 32'h0);
    tbl[18] = mk(1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h2,        1'b0, 32'h0,        1'b0, 32'h0);
    tbl[19] = mk(1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h2,        1'b0, 32'h0,        1'b0, 32'h0);
    tbl[20] = mk(1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h2,        1'b0, 32'h0,        1'b0, 32'h0);
    tbl[21] = mk(1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h2,        1'b0, 32'h0,        1'b0, 32'h0);
    tbl[22] = mk(1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h2,        1'b0, 32'h0,        1'b0, 32'h0);
    tbl[23] = mk(1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h3,        1'b1, 32'h2,        1'b0, 32'h0);
    tbl[24] = mk(1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h4,        1'b1, 32'h3,        1'b0, 32'h0);
    tbl[25] = mk(1'b1, 32'h40,       1'b1, 1'b1, 1'b0, 32'h4,        1'b0, 32'h0,        1'b0, 32'h0);
    tbl[26] = mk(1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h40,       1'b0, 32'h0,        1'b0, 32'h0);
    tbl[27] = mk(1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h40,       1'b0, 32'h0,        1'b0, 32'h0);
    tbl[28] = mk(1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h41,       1'b1, 32'h40,       1'b0, 32'h0);
    tbl[29] = mk(1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h42,       1'b1, 32'h41,       1'b0, 32'h0);
    tbl[30] = mk(1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h43,       1'b1, 32'h41,       1'b0, 32'h0);
    // Segment B (after mid-run reset): decode stalled from cycle 0, then resumes.
    tbl[31] = mk(1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'd0);
    tbl[32] = mk(1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0,        1'b0, 32'h0,        1'b1, 32'd0);
    tbl[33] = mk(1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h1,        1'b1, 32'h0,        1'b1, 32'd0);
    tbl[34] = mk(1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h2,        1'b1, 32'h0,        1'b1, 32'd0);
    tbl[35] = mk(1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h2,        1'b1, 32'h0,        1'b1, 32'd1);
    tbl[36] = mk(1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h2,        1'b1, 32'h0,        1'b1, 32'd2);
    tbl[37] = mk(1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h2,        1'b1, 32'h0,        1'b1, 32'd3);
    tbl[38] = mk(1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h3,        1'b1, 32'h1,        1'b1, 32'd3);
    tbl[39] = mk(1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h4,        1'b1, 32'h2,        1'b1, 32'd3);

    rst         = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    halt        = 1'b0;
    instr_rdy   = 1'b0;

    @(negedge clk);
    #1;
    chk("rst.mem_rd_en", {31'd0, mem_rd_en}, 32'd0);
    chk("rst.mem_addr", mem_addr, 32'h0);
    chk("rst.instr_vld", {31'd0, instr_vld}, 32'd0);
    chk("rst.instr_out", instr_out, 32'h0);
    chk("rst.instr_pc", instr_pc, 32'h0);
`ifdef IFETCH_STALL_CNT_EN
    chk("rst.stall_cnt", stall_cnt, 32'h0);
`endif

    // Release reset at a falling edge; that cycle is cycle 0.
    @(negedge clk);
    rst = 1'b0;
    apply_vec(0);
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      apply_vec(i);
    end

    // Asynchronous reset with the queue full: outputs clear without a clock edge.
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst.instr_vld", {31'd0, instr_vld}, 32'd0);
    chk("midrst.mem_addr", mem_addr, 32'h0);
    chk("midrst.mem_rd_en", {31'd0, mem_rd_en}, 32'd0);
    chk("midrst.instr_out", instr_out, 32'h0);
    chk("midrst.instr_pc", instr_pc, 32'h0);

    @(negedge clk);
    rst = 1'b0;
    apply_vec(31);
    for (int i = 32; i <= 39; i++) begin
      @(negedge clk);
      apply_vec(i);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch_ctrl.md
# instr_fetch_ctrl

Fetch controller that sequences reads of the word-addressed instruction memory and feeds a small prefetch queue to the decode stage. Owns the program counter, issues one read per cycle while queue space exists, and presents instructions with a valid/ready handshake. Handles branch redirects (queue flush plus PC reload) and a halt request. Sits between the CPU control path and the instruction memory, which latches its output during the low phase of `clk`.

## Interface
- `DEPTH`, 2: prefetch queue entries; power of two, ≥2.
- `RESET_PC`, 32'h0000_0000: PC loaded on reset (word address).

- `clk` in 1: clock, rising-edge logic.
- `rst` in 1: asynchronous, active-high reset.
- `mem_addr` out 32: word address to instruction memory; always equals the PC register.
- `mem_rd_en` out 1: read request for the current cycle.
- `mem_instr` in 32: memory read data; stable at the rising edge that ends the issue cycle.
- `redirect` in 1: branch/jump taken; load `redirect_pc` and flush.
- `redirect_pc` in 32: new word address.
- `halt` in 1: suppress new issues while high.
- `instr_out` out 32: instruction at queue head.
- `instr_pc` out 32: word address of `instr_out`.
- `instr_vld` out 1: queue head valid.
- `instr_rdy` in 1: decode accepts head when `instr_vld`=1.
- `stall_cnt` out 32: present only with `IFETCH_STALL_CNT_EN`.

## Operation
- States: IDLE, FETCH, HALT. Reset enters IDLE. IDLE→FETCH unconditionally next cycle (HALT if `halt`=1). FETCH→HALT when `halt`=1; HALT→FETCH when `halt`=0.
- Pop = `instr_vld & instr_rdy`. Issue = state FETCH & `halt`=0 & (count<DEPTH | pop). `mem_rd_en` = issue. It depends only on registered state, `halt` and `instr_rdy`.
- On an issue edge without redirect: push {PC, `mem_instr`} at queue tail, PC←PC+1 (wraps 32'hFFFF_FFFF→0).
- Queue: circular buffer with count 0..DEPTH. Simultaneous push and pop when full keeps count at DEPTH. Pop when empty is impossible because `instr_vld`=0. `instr_vld` = count≠0; `instr_out`/`instr_pc` = head entry, registered.
- Redirect (any state): on that edge the queue is emptied, PC←`redirect_pc`, and any issue in that cycle is discarded (no push, no PC increment). A pop in the same cycle is still a valid consumption. Redirect does not change state; redirect while HALT loads PC and fetch resumes at it once `halt` drops.
- Reset mid-operation: immediate flush; all outputs return to reset values.
- Reset values: `mem_addr`=RESET_PC, `mem_rd_en`=0, `instr_vld`=0, `instr_out`=0, `instr_pc`=0, `stall_cnt`=0, count=0.

## Timing
- Cycle 0 (first after reset release): IDLE, `mem_rd_en`=0.
- Cycle 1: `mem_rd_en`=1, `mem_addr`=RESET_PC.
- Cycle 2: `instr_vld`=1 with mem[RESET_PC]; `mem_addr`=RESET_PC+1.
- Issue-to-valid latency: 1 cycle. Sustained throughput: 1 instr/cycle with `instr_rdy` held high.
- Redirect asserted in cycle N: `mem_addr`=`redirect_pc` in N+1; `instr_vld`=0 in N+1; target instruction valid in N+2.
- `halt` rising in cycle N: no issue in N. Queued entries keep draining.

## Configuration
- `IFETCH_STALL_CNT_EN` defined: adds `stall_cnt`. It increments in each cycle with state FETCH, `halt`=0, count=DEPTH and no pop. It saturates at 32'hFFFF_FFFF and is cleared only by `rst`.
- Undefined: port and counter are absent; all other behaviour is identical.

## Test plan
- Reset release, mem[0..3]=A0..A3, `instr_rdy`=1 -> `instr_vld` from cycle 2, outputs A0,A1,A2,A3 with `instr_pc` 0,1,2,3 on consecutive cycles.
- `instr_rdy`=0 from cycle 0, DEPTH=2 -> exactly 2 issues, then `mem_rd_en`=0 with `mem_addr`=2. With the counter enabled, `stall_cnt` grows by 1/cycle. Raising `instr_rdy` resumes at 1 instr/cycle with no skipped or duplicated PCs.
- Redirect to 32'h100 while queue holds PCs 5,6 -> next cycle `instr_vld`=0 and `mem_addr`=32'h100. The following cycle `instr_pc`=32'h100. PCs 5,6 and the in-flight 7 are never presented.
- `halt` held 4 cycles in steady state -> no `mem_rd_en` during halt, queue drains to empty, fetch resumes at the next sequential PC.
- `redirect_pc`=32'hFFFF_FFFF -> `instr_pc` sequence FFFF_FFFF, 0, 1.
- `rst` pulsed with queue full -> `instr_vld`=0 immediately, `mem_addr`=RESET_PC, sequence restarts per cycle-0 timing.
